// File: rtl/reset_sequencer_if.sv
// Signal bundle between a reset sequencer and the logic that requests and consumes
// its staged resets. master = requester/consumer side, slave = the sequencer.
interface reset_sequencer_if #(
    parameter int NSTAGE = 4
);
    // rst_req is a one-cycle pulse with no acknowledge: every cycle it is high at an
    // edge restarts the sequence. locked is a level, sampled on every edge.
    logic              rst_req;
    logic              locked;
    logic [NSTAGE-1:0] rst_out;
    logic              busy;
    logic              done;
    logic [7:0]        seq_count;
    logic [1:0]        state;

    modport master (
        output rst_req, locked,
        input  rst_out, busy, done, seq_count, state
    );

    modport slave (
        input  rst_req, locked,
        output rst_out, busy, done, seq_count, state
    );
endinterface

// File: rtl/reset_sequencer.sv
// Holds NSTAGE stage resets asserted until the clock is locked for HOLD cycles, then
// releases them in index order STEP cycles apart; reports busy/done and a sequence count.
module reset_sequencer #(
    parameter int NSTAGE = 4,
    parameter int HOLD   = 16,
    parameter int STEP   = 8
) (
    input  logic               clk,
    input  logic               aresetn,
    reset_sequencer_if.slave   bus
);
    localparam int CMAX = (HOLD > STEP) ? HOLD : STEP;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam int IW   = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD - 1);
    localparam logic [CW-1:0] STEP_LAST = CW'(STEP - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NSTAGE - 1);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [NSTAGE-1:0] rst_q, rst_d;
    logic [7:0]        seq_q, seq_d;
    logic              busy_q, done_q;
    logic              armed_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rst_d   = rst_q;
        seq_d   = seq_q;
        // The first edge after aresetn rises is treated like a request edge, so a
        // power-on sequence has exactly the same timing as an rst_req sequence.
        if (bus.rst_req || !armed_q) begin
            state_d = ST_ASSERT;
            cnt_d   = '0;
            idx_d   = '0;
            rst_d   = '1;
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    rst_d = '1;
                    if (!bus.locked) begin
                        cnt_d = '0;
                    end else if (cnt_q == HOLD_LAST) begin
                        state_d = ST_RELEASE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (!bus.locked) begin
                        state_d = ST_ASSERT;
                        cnt_d   = '0;
                        idx_d   = '0;
                        rst_d   = '1;
                    end else if (cnt_q == STEP_LAST) begin
                        // Shifting in a zero keeps rst_out thermometer-shaped.
                        rst_d = rst_q << 1;
                        cnt_d = '0;
                        if (idx_q == IDX_LAST) begin
                            state_d = ST_DONE;
                            idx_d   = '0;
                            seq_d   = seq_q + 8'd1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    rst_d = '0;
                    if (!bus.locked) begin
                        state_d = ST_ASSERT;
                        cnt_d   = '0;
                        idx_d   = '0;
                        rst_d   = '1;
                    end
                end
                default: begin
                    state_d = ST_ASSERT;
                    cnt_d   = '0;
                    idx_d   = '0;
                    rst_d   = '1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_ASSERT;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_q   <= '1;
            seq_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            seq_q   <= seq_d;
            busy_q  <= (state_d != ST_DONE);
            done_q  <= (state_d == ST_DONE);
            armed_q <= 1'b1;
        end
    end

    assign bus.rst_out   = rst_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.seq_count = seq_q;
    assign bus.state     = state_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: a 4/16/8 instance for the timing scenarios and a 1/1/1
// instance for back-to-back wrap, both checked against a lock-progress model.
module tb_reset_sequencer;
    logic clk = 1'b0;
    logic aresetn = 1'b0;
    int   vectors = 0;
    int   errors  = 0;

    always #5 clk = ~clk;

    reset_sequencer_if #(.NSTAGE(4)) ifa ();
    reset_sequencer_if #(.NSTAGE(1)) ifb ();

    reset_sequencer #(.NSTAGE(4), .HOLD(16), .STEP(8)) dut_a (
        .clk(clk), .aresetn(aresetn), .bus(ifa)
    );
    reset_sequencer #(.NSTAGE(1), .HOLD(1), .STEP(1)) dut_b (
        .clk(clk), .aresetn(aresetn), .bus(ifb)
    );

    // Model: p = locked-high edges since the last restart, saturating at the total
    // sequence length. Stage k is released once p reaches HOLD+(k+1)*STEP.
    localparam int TOT_A = 16 + 4 * 8;
    localparam int TOT_B = 1 + 1 * 1;
    int       p_a, p_b;
    logic [7:0] s_a, s_b;
    bit       fresh_a, fresh_b;
    logic [3:0] ea_rst, eb_rst;
    logic     ea_done, eb_done;

    function automatic logic [3:0] exp_rst(int p, int ns, int h, int s);
        logic [3:0] r;
        r = '0;
        for (int k = 0; k < ns; k++) r[k] = (p < h + (k + 1) * s);
        return r;
    endfunction

    always @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            p_a = 0; s_a = 8'd0; fresh_a = 1'b1;
            p_b = 0; s_b = 8'd0; fresh_b = 1'b1;
        end else begin
            if (ifa.rst_req || fresh_a || !ifa.locked) p_a = 0;
            else if (p_a < TOT_A) begin
                p_a++;
                if (p_a == TOT_A) s_a = s_a + 8'd1;
            end
            fresh_a = 1'b0;
            if (ifb.rst_req || fresh_b || !ifb.locked) p_b = 0;
            else if (p_b < TOT_B) begin
                p_b++;
                if (p_b == TOT_B) s_b = s_b + 8'd1;
            end
            fresh_b = 1'b0;
        end
    end

    always_comb begin
        ea_rst  = exp_rst(p_a, 4, 16, 8);
        ea_done = (p_a >= TOT_A);
        eb_rst  = exp_rst(p_b, 1, 1, 1);
        eb_done = (p_b >= TOT_B);
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_a();
        ifa.rst_req = 1'b1;
        tick();
        ifa.rst_req = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        ifa.rst_req = 1'b0; ifa.locked = 1'b1;
        ifb.rst_req = 1'b0; ifb.locked = 1'b1;
        repeat (5) tick();
        vectors++;
        if ({ifa.rst_out, ifa.busy, ifa.done, ifa.seq_count} !== {4'b1111, 1'b1, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL reset_hold: rst_out=%b busy=%b done=%b seq=%0d, want 1111 1 0 0",
                     ifa.rst_out, ifa.busy, ifa.done, ifa.seq_count);
        end
        aresetn = 1'b1;
        tick();
        for (int i = 1; i <= 50; i++) begin
            tick();
            vectors++;
            if ({ifa.rst_out, ifa.busy, ifa.done, ifa.seq_count} !== {ea_rst, ~ea_done, ea_done, s_a}) begin
                errors++;
                $display("FAIL reset_seq_model edge %0d: rst_out=%b busy=%b done=%b seq=%0d, want %b %b %b %0d",
                         i, ifa.rst_out, ifa.busy, ifa.done, ifa.seq_count, ea_rst, ~ea_done, ea_done, s_a);
            end
            if (i == 23 || i == 24 || i == 32 || i == 40 || i == 48) begin
                logic [3:0] want;
                want = (i == 23) ? 4'b1111 : (4'b1111 << ((i - 16) / 8));
                vectors++;
                if (ifa.rst_out !== want) begin
                    errors++;
                    $display("FAIL reset_seq_edge %0d: rst_out=%b, want %b", i, ifa.rst_out, want);
                end
            end
            if (i == 47 || i == 48) begin
                vectors++;
                if ({ifa.done, ifa.seq_count} !== {(i == 48), (i == 48) ? 8'd1 : 8'd0}) begin
                    errors++;
                    $display("FAIL reset_seq_done edge %0d: done=%b seq=%0d", i, ifa.done, ifa.seq_count);
                end
            end
        end
    endtask

    task automatic test_done_req();
        pulse_a();
        vectors++;
        if ({ifa.rst_out, ifa.busy, ifa.done} !== {4'b1111, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL done_req_restart: rst_out=%b busy=%b done=%b, want 1111 1 0",
                     ifa.rst_out, ifa.busy, ifa.done);
        end
        for (int i = 1; i <= 48; i++) begin
            tick();
            vectors++;
            if ({ifa.rst_out, ifa.busy, ifa.done, ifa.seq_count} !== {ea_rst, ~ea_done, ea_done, s_a}) begin
                errors++;
                $display("FAIL done_req_model edge %0d: rst_out=%b done=%b seq=%0d, want %b %b %0d",
                         i, ifa.rst_out, ifa.done, ifa.seq_count, ea_rst, ea_done, s_a);
            end
        end
        vectors++;
        if ({ifa.done, ifa.seq_count} !== {1'b1, 8'd2}) begin
            errors++;
            $display("FAIL done_req_count: done=%b seq=%0d, want 1 2", ifa.done, ifa.seq_count);
        end
    endtask

    task automatic test_lock_loss();
        int n;
        pulse_a();
        repeat (32) tick();
        vectors++;
        if (ifa.rst_out !== 4'b1100) begin
            errors++;
            $display("FAIL lock_loss_pre: rst_out=%b, want 1100", ifa.rst_out);
        end
        ifa.locked = 1'b0;
        n = $urandom_range(3, 10);
        for (int j = 0; j < n; j++) begin
            tick();
            vectors++;
            if ({ifa.rst_out, ifa.busy, ifa.done} !== {4'b1111, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL lock_loss_low cycle %0d: rst_out=%b busy=%b done=%b, want 1111 1 0",
                         j, ifa.rst_out, ifa.busy, ifa.done);
            end
        end
        ifa.locked = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            tick();
            vectors++;
            if (ifa.rst_out !== ea_rst) begin
                errors++;
                $display("FAIL lock_loss_model edge %0d: rst_out=%b, want %b", i, ifa.rst_out, ea_rst);
            end
            if (i >= 23) begin
                vectors++;
                if (ifa.rst_out !== ((i == 24) ? 4'b1110 : 4'b1111)) begin
                    errors++;
                    $display("FAIL lock_loss_relock edge %0d: rst_out=%b", i, ifa.rst_out);
                end
            end
        end
    endtask

    task automatic test_double_req();
        pulse_a();
        repeat (10) tick();
        pulse_a();
        for (int i = 1; i <= 24; i++) begin
            tick();
            vectors++;
            if (ifa.rst_out !== ea_rst) begin
                errors++;
                $display("FAIL double_req_model edge %0d: rst_out=%b, want %b", i, ifa.rst_out, ea_rst);
            end
            if (i >= 23) begin
                vectors++;
                if (ifa.rst_out[0] !== (i == 23)) begin
                    errors++;
                    $display("FAIL double_req_bit0 edge %0d: rst_out[0]=%b, want %b", i, ifa.rst_out[0], (i == 23));
                end
            end
        end
    endtask

    task automatic test_async_mid();
        pulse_a();
        repeat (30) tick();
        #2;
        aresetn = 1'b0;
        #1;
        vectors++;
        if ({ifa.rst_out, ifa.busy, ifa.done, ifa.seq_count} !== {4'b1111, 1'b1, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL async_mid: rst_out=%b busy=%b done=%b seq=%0d, want 1111 1 0 0",
                     ifa.rst_out, ifa.busy, ifa.done, ifa.seq_count);
        end
        @(negedge clk);
        aresetn = 1'b1;
        tick();
        for (int i = 1; i <= 48; i++) begin
            tick();
            vectors++;
            if ({ifa.rst_out, ifa.busy, ifa.done, ifa.seq_count} !== {ea_rst, ~ea_done, ea_done, s_a}) begin
                errors++;
                $display("FAIL async_mid_model edge %0d: rst_out=%b done=%b seq=%0d, want %b %b %0d",
                         i, ifa.rst_out, ifa.done, ifa.seq_count, ea_rst, ea_done, s_a);
            end
        end
    endtask

    task automatic test_random();
        int low_left = 0;
        for (int i = 0; i < 600; i++) begin
            if (low_left > 0) begin
                ifa.locked = 1'b0;
                low_left--;
            end else begin
                ifa.locked = 1'b1;
                if ($urandom_range(0, 59) == 0) low_left = $urandom_range(1, 5);
            end
            ifa.rst_req = ($urandom_range(0, 149) == 0);
            ifb.locked  = ($urandom_range(0, 9) != 0);
            ifb.rst_req = ($urandom_range(0, 7) == 0);
            tick();
            vectors++;
            if ({ifa.rst_out, ifa.busy, ifa.done, ifa.seq_count} !== {ea_rst, ~ea_done, ea_done, s_a} ||
                {ifb.rst_out, ifb.busy, ifb.done, ifb.seq_count} !== {eb_rst[0], ~eb_done, eb_done, s_b}) begin
                errors++;
                $display("FAIL random cycle %0d: a=%b/%b/%0d want %b/%b/%0d b=%b/%b/%0d want %b/%b/%0d",
                         i, ifa.rst_out, ifa.done, ifa.seq_count, ea_rst, ea_done, s_a,
                         ifb.rst_out, ifb.done, ifb.seq_count, eb_rst[0], eb_done, s_b);
            end
        end
        ifa.rst_req = 1'b0; ifa.locked = 1'b1;
        ifb.rst_req = 1'b0; ifb.locked = 1'b1;
    endtask

    task automatic test_back_to_back();
        aresetn = 1'b0;
        repeat (2) tick();
        aresetn = 1'b1;
        repeat (3) tick();
        vectors++;
        if ({ifb.rst_out, ifb.done, ifb.seq_count} !== {1'b0, 1'b1, 8'd1}) begin
            errors++;
            $display("FAIL wrap_first: rst_out=%b done=%b seq=%0d, want 0 1 1",
                     ifb.rst_out, ifb.done, ifb.seq_count);
        end
        for (int n = 0; n < 255; n++) begin
            ifb.rst_req = 1'b1;
            tick();
            ifb.rst_req = 1'b0;
            for (int e = 1; e <= 2; e++) begin
                tick();
                vectors++;
                if ({ifb.rst_out, ifb.busy, ifb.done, ifb.seq_count} !== {eb_rst[0], ~eb_done, eb_done, s_b}) begin
                    errors++;
                    $display("FAIL wrap_model seq %0d edge %0d: rst_out=%b done=%b seq=%0d, want %b %b %0d",
                             n, e, ifb.rst_out, ifb.done, ifb.seq_count, eb_rst[0], eb_done, s_b);
                end
            end
        end
        vectors++;
        if ({ifb.done, ifb.seq_count} !== {1'b1, 8'd0}) begin
            errors++;
            $display("FAIL wrap_count: done=%b seq=%0d, want 1 0", ifb.done, ifb.seq_count);
        end
        ifb.rst_req = 1'b1;
        ifb.locked  = 1'b0;
        tick();
        ifb.rst_req = 1'b0;
        vectors++;
        if ({ifb.rst_out, ifb.busy, ifb.done} !== {1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL req_lock_same: rst_out=%b busy=%b done=%b, want 1 1 0",
                     ifb.rst_out, ifb.busy, ifb.done);
        end
        ifb.locked = 1'b1;
        for (int e = 1; e <= 2; e++) begin
            tick();
            vectors++;
            if ({ifb.rst_out, ifb.done, ifb.seq_count} !== {(e == 1), (e == 2), (e == 2) ? 8'd1 : 8'd0}) begin
                errors++;
                $display("FAIL req_lock_relock edge %0d: rst_out=%b done=%b seq=%0d",
                         e, ifb.rst_out, ifb.done, ifb.seq_count);
            end
        end
    endtask

    initial begin
        test_reset();
        test_done_req();
        test_lock_loss();
        test_double_req();
        test_async_mid();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
